// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared constants for the CP0 exception sequencer: ExcCodes, CP0 register
// numbers, Status bit positions and the sequencer state encoding.
package cp0_exc_ctrl_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_TR   = 5'd13;

  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;

  // Bit positions inside the MEM-stage exception flag vector.
  localparam int EV_ADEL = 0;
  localparam int EV_RI   = 1;
  localparam int EV_OV   = 2;
  localparam int EV_TR   = 3;
  localparam int EV_SYS  = 4;
  localparam int EV_BP   = 5;
  localparam int EV_ADES = 6;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    S_EPC    = 3'd1,
    S_CAUSE  = 3'd2,
    S_STATUS = 3'd3,
    S_REDIR  = 3'd4
  } state_e;

  typedef struct packed {
    logic       take;
    logic [4:0] code;
    logic       is_eret;
  } prio_t;

endpackage

// File: rtl/cp0_exc_ctrl_prio_enc.sv
// Priority encoder choosing which pending event the sequencer services:
// interrupt first, then synchronous exceptions, ERET last.
module exc_prio_enc
  import cp0_exc_ctrl_pkg::*;
(
  input  logic       int_pend_i,
  input  logic [6:0] exc_vec_i,
  input  logic       eret_i,
  output prio_t      prio_o
);

  always_comb begin
    prio_o         = '0;
    prio_o.take    = int_pend_i | (|exc_vec_i) | eret_i;
    if (int_pend_i)             prio_o.code = EXC_INT;
    else if (exc_vec_i[EV_ADEL]) prio_o.code = EXC_ADEL;
    else if (exc_vec_i[EV_RI])   prio_o.code = EXC_RI;
    else if (exc_vec_i[EV_OV])   prio_o.code = EXC_OV;
    else if (exc_vec_i[EV_TR])   prio_o.code = EXC_TR;
    else if (exc_vec_i[EV_SYS])  prio_o.code = EXC_SYS;
    else if (exc_vec_i[EV_BP])   prio_o.code = EXC_BP;
    else if (exc_vec_i[EV_ADES]) prio_o.code = EXC_ADES;
    else if (eret_i)             prio_o.is_eret = 1'b1;
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt sequencer: commits EPC, Cause and Status through the
// single CP0 write port over successive cycles, then redirects the PC.
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEFAULT,
  parameter logic [4:0]  ADDR_EPC    = CP0_REG_EPC,
  parameter logic [4:0]  ADDR_CAUSE  = CP0_REG_CAUSE,
  parameter logic [4:0]  ADDR_STATUS = CP0_REG_STATUS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_dslot_i,
  input  logic [6:0]  exc_vec_i,
  input  logic        eret_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_waddr_i,
  input  logic [31:0] wb_wdata_i,
  output logic        cp0_we_o,
  output logic [4:0]  cp0_waddr_o,
  output logic [31:0] cp0_wdata_o,
  output logic        cause_we_o,
  output logic [4:0]  exccode_o,
  output logic        bd_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        redirect_o,
  output logic [31:0] new_pc_o
);

  state_e      state_q, state_d;
  logic [4:0]  code_q;
  logic        is_eret_q;
  logic [31:0] epc_val_q;
  logic        bd_q;
  logic [31:0] status_q;
  logic [31:0] epc_q;

  logic        int_pend;
  prio_t       prio;
  logic        accept;
  logic        wb_fwd;
  logic [31:0] status_fwd;
  logic [31:0] epc_fwd;
  logic        unused_cause;

  assign unused_cause = ^{cp0_cause_i[31:16], cp0_cause_i[7:0], ADDR_CAUSE};

  assign int_pend = cp0_status_i[STATUS_IE] & ~cp0_status_i[STATUS_EXL] &
                    (|(cp0_cause_i[15:8] & cp0_status_i[15:8]));

  exc_prio_enc u_prio (
    .int_pend_i (int_pend),
    .exc_vec_i  (exc_vec_i),
    .eret_i     (eret_i),
    .prio_o     (prio)
  );

  assign accept = (state_q == IDLE) & mem_valid_i & prio.take;

  // A WB MTC0 forwarded in the accept cycle must be visible to the sequence,
  // so the Status/EPC snapshots bypass the not-yet-updated CP0 values.
  assign wb_fwd     = rst & wb_we_i;
  assign status_fwd = (wb_fwd && wb_waddr_i == ADDR_STATUS) ? wb_wdata_i : cp0_status_i;
  assign epc_fwd    = (wb_fwd && wb_waddr_i == ADDR_EPC)    ? wb_wdata_i : cp0_epc_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      code_q    <= '0;
      is_eret_q <= 1'b0;
      epc_val_q <= '0;
      bd_q      <= 1'b0;
      status_q  <= '0;
      epc_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        code_q    <= prio.code;
        is_eret_q <= prio.is_eret;
        epc_val_q <= mem_in_dslot_i ? (mem_pc_i - 32'd4) : mem_pc_i;
        bd_q      <= mem_in_dslot_i;
        status_q  <= status_fwd;
        epc_q     <= epc_fwd;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cp0_we_o    = 1'b0;
    cp0_waddr_o = '0;
    cp0_wdata_o = '0;
    cause_we_o  = 1'b0;
    exccode_o   = '0;
    bd_o        = 1'b0;
    flush_o     = 1'b0;
    stall_o     = 1'b0;
    redirect_o  = 1'b0;
    new_pc_o    = '0;

    unique case (state_q)
      IDLE: begin
        if (wb_fwd) begin
          cp0_we_o    = 1'b1;
          cp0_waddr_o = wb_waddr_i;
          cp0_wdata_o = wb_wdata_i;
        end
        if (accept) state_d = prio.is_eret ? S_STATUS : S_EPC;
      end
      S_EPC: begin
        flush_o     = 1'b1;
        stall_o     = 1'b1;
        cp0_we_o    = 1'b1;
        cp0_waddr_o = ADDR_EPC;
        cp0_wdata_o = epc_val_q;
        state_d     = S_CAUSE;
      end
      S_CAUSE: begin
        stall_o    = 1'b1;
        cause_we_o = 1'b1;
        exccode_o  = code_q;
        bd_o       = bd_q;
        state_d    = S_STATUS;
      end
      S_STATUS: begin
        // ERET enters here directly, so the flush pulse belongs to it.
        flush_o     = is_eret_q;
        stall_o     = 1'b1;
        cp0_we_o    = 1'b1;
        cp0_waddr_o = ADDR_STATUS;
        cp0_wdata_o = is_eret_q ? (status_q & ~32'h2) : (status_q | 32'h2);
        state_d     = S_REDIR;
      end
      S_REDIR: begin
        stall_o    = ~is_eret_q;
        redirect_o = 1'b1;
        new_pc_o   = is_eret_q ? epc_q : EXC_VECTOR;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed scenarios with literal
// expectations plus a randomized run against a queue-based reference model.
module tb_cp0_exc_ctrl;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        causeWe;
    logic [4:0]  exccode;
    logic        bd;
    logic        flush;
    logic        stall;
    logic        redirect;
    logic [31:0] newPc;
  } outs_t;

  logic        clk;
  logic        rst;
  logic        memValid;
  logic [31:0] memPc;
  logic        memDslot;
  logic [6:0]  excVec;
  logic        eret;
  logic [31:0] cp0Status;
  logic [31:0] cp0Cause;
  logic [31:0] cp0Epc;
  logic        wbWe;
  logic [4:0]  wbWaddr;
  logic [31:0] wbWdata;

  logic        cp0We;
  logic [4:0]  cp0Waddr;
  logic [31:0] cp0Wdata;
  logic        causeWe;
  logic [4:0]  exccode;
  logic        bd;
  logic        flush;
  logic        stall;
  logic        redirect;
  logic [31:0] newPc;

  int checks = 0;
  int errors = 0;

  outs_t expQ[$];
  outs_t pendQ[$];
  outs_t expOut;
  logic  modelAccept;
  logic  pinEn;
  outs_t pinExp;
  int    redirCount;
  int    leakCount;

  // ExcCode for each flag bit; bit order is also priority order.
  logic [4:0] codeOf [7] = '{5'd4, 5'd10, 5'd12, 5'd13, 5'd8, 5'd9, 5'd5};

  cp0_exc_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .mem_valid_i    (memValid),
    .mem_pc_i       (memPc),
    .mem_in_dslot_i (memDslot),
    .exc_vec_i      (excVec),
    .eret_i         (eret),
    .cp0_status_i   (cp0Status),
    .cp0_cause_i    (cp0Cause),
    .cp0_epc_i      (cp0Epc),
    .wb_we_i        (wbWe),
    .wb_waddr_i     (wbWaddr),
    .wb_wdata_i     (wbWdata),
    .cp0_we_o       (cp0We),
    .cp0_waddr_o    (cp0Waddr),
    .cp0_wdata_o    (cp0Wdata),
    .cause_we_o     (causeWe),
    .exccode_o      (exccode),
    .bd_o           (bd),
    .flush_o        (flush),
    .stall_o        (stall),
    .redirect_o     (redirect),
    .new_pc_o       (newPc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t mkWrite(input logic [4:0] a, input logic [31:0] d,
                                    input logic fl, input logic st);
    outs_t o = '0;
    o.we = 1'b1; o.waddr = a; o.wdata = d; o.flush = fl; o.stall = st;
    return o;
  endfunction

  function automatic outs_t mkCause(input logic [4:0] c, input logic b);
    outs_t o = '0;
    o.causeWe = 1'b1; o.exccode = c; o.bd = b; o.stall = 1'b1;
    return o;
  endfunction

  function automatic outs_t mkRedir(input logic [31:0] pc, input logic st);
    outs_t o = '0;
    o.redirect = 1'b1; o.newPc = pc; o.stall = st;
    return o;
  endfunction

  // Expected outputs for the current cycle, plus the sequence an accept would start.
  task automatic computeExpected();
    logic        intPend;
    logic [4:0]  code;
    logic        isEret;
    logic [31:0] snapStatus;
    logic [31:0] snapEpc;
    logic [31:0] epcVal;
    modelAccept = 1'b0;
    pendQ.delete();
    expOut = '0;
    if (!rst) return;
    if (expQ.size() != 0) begin
      expOut = expQ[0];
      return;
    end
    if (wbWe) begin
      expOut.we = 1'b1; expOut.waddr = wbWaddr; expOut.wdata = wbWdata;
    end
    intPend = cp0Status[0] && !cp0Status[1] && ((cp0Cause[15:8] & cp0Status[15:8]) != 8'd0);
    if (!(memValid && (intPend || excVec != 7'd0 || eret))) return;
    modelAccept = 1'b1;
    isEret = 1'b0;
    code = 5'd0;
    if (!intPend) begin
      if (excVec == 7'd0) isEret = 1'b1;
      else for (int i = 6; i >= 0; i--) if (excVec[i]) code = codeOf[i];
    end
    snapStatus = (wbWe && wbWaddr == 5'd12) ? wbWdata : cp0Status;
    snapEpc    = (wbWe && wbWaddr == 5'd14) ? wbWdata : cp0Epc;
    epcVal     = memDslot ? memPc - 32'd4 : memPc;
    if (isEret) begin
      pendQ.push_back(mkWrite(5'd12, snapStatus & ~32'h2, 1'b1, 1'b1));
      pendQ.push_back(mkRedir(snapEpc, 1'b0));
    end else begin
      pendQ.push_back(mkWrite(5'd14, epcVal, 1'b1, 1'b1));
      pendQ.push_back(mkCause(code, memDslot));
      pendQ.push_back(mkWrite(5'd12, snapStatus | 32'h2, 1'b0, 1'b1));
      pendQ.push_back(mkRedir(32'hBFC00380, 1'b1));
    end
  endtask

  task automatic advanceModel();
    if (!rst) expQ.delete();
    else if (expQ.size() != 0) void'(expQ.pop_front());
    else if (modelAccept) expQ = pendQ;
  endtask

  task automatic checkOutput(input string name, input outs_t exp);
    outs_t act;
    act = {cp0We, cp0Waddr, cp0Wdata, causeWe, exccode, bd, flush, stall, redirect, newPc};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got we=%0b a=%0d d=%h cwe=%0b ec=%0d bd=%0b fl=%0b st=%0b rd=%0b pc=%h, want we=%0b a=%0d d=%h cwe=%0b ec=%0d bd=%0b fl=%0b st=%0b rd=%0b pc=%h",
               name, act.we, act.waddr, act.wdata, act.causeWe, act.exccode, act.bd,
               act.flush, act.stall, act.redirect, act.newPc,
               exp.we, exp.waddr, exp.wdata, exp.causeWe, exp.exccode, exp.bd,
               exp.flush, exp.stall, exp.redirect, exp.newPc);
    end
  endtask

  task automatic checkCount(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // One clock cycle: inputs already driven; compare at negedge, then advance.
  task automatic stepCycle(input string name);
    computeExpected();
    @(negedge clk);
    checkOutput({"model ", name}, expOut);
    if (pinEn) checkOutput({"pin ", name}, pinExp);
    pinEn = 1'b0;
    redirCount += int'(redirect);
    leakCount  += int'(cp0We && cp0Waddr == 5'd11);
    @(posedge clk);
    advanceModel();
    #1;
  endtask

  task automatic pin(input outs_t o);
    pinEn  = 1'b1;
    pinExp = o;
  endtask

  task automatic quiet();
    memValid = 0; memPc = 0; memDslot = 0; excVec = 0; eret = 0;
    cp0Status = 0; cp0Cause = 0; cp0Epc = 0; wbWe = 0; wbWaddr = 0; wbWdata = 0;
  endtask

  task automatic applyStimulus();
    memValid  = ($urandom_range(0, 9) < 7);
    memPc     = $urandom & 32'hFFFF_FFFC;
    memDslot  = $urandom_range(0, 1) == 1;
    excVec    = ($urandom_range(0, 9) < 2) ? 7'($urandom) : 7'd0;
    eret      = $urandom_range(0, 9) == 0;
    cp0Status = $urandom;
    cp0Cause  = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
    cp0Epc    = $urandom;
    wbWe      = $urandom_range(0, 3) == 0;
    wbWaddr   = 5'($urandom_range(10, 14));
    wbWdata   = $urandom;
    if ($urandom_range(0, 199) == 0) rst = 1'b0;
    else rst = 1'b1;
  endtask

  task automatic runSeq(input string name, input logic [4:0] code);
    pin(mkCause(code, 1'b0));
    stepCycle({name, " T+2"});
    quiet(); stepCycle({name, " T+3"});
    stepCycle({name, " T+4"});
  endtask

  initial begin
    pinEn = 1'b0;
    redirCount = 0;
    leakCount = 0;
    rst = 1'b0;
    quiet();
    wbWe = 1; wbWaddr = 5'd11; wbWdata = 32'hDEADBEEF;
    pin('0); stepCycle("reset");
    quiet();
    rst = 1'b1;
    pin('0); stepCycle("idle after reset");

    // Syscall, not in a delay slot.
    memValid = 1; memPc = 32'h80000100; excVec = 7'b0010000; cp0Status = 32'h10000001;
    pin('0); stepCycle("sys T");
    quiet();
    pin(mkWrite(5'd14, 32'h80000100, 1'b1, 1'b1)); stepCycle("sys T+1");
    pin(mkCause(5'd8, 1'b0)); stepCycle("sys T+2");
    pin(mkWrite(5'd12, 32'h10000003, 1'b0, 1'b1)); stepCycle("sys T+3");
    pin(mkRedir(32'hBFC00380, 1'b1)); stepCycle("sys T+4");
    pin('0); stepCycle("sys T+5");

    // Overflow in a delay slot.
    memValid = 1; memPc = 32'h80000204; memDslot = 1; excVec = 7'b0000100;
    stepCycle("ov T");
    quiet();
    pin(mkWrite(5'd14, 32'h80000200, 1'b1, 1'b1)); stepCycle("ov T+1");
    pin(mkCause(5'd12, 1'b1)); stepCycle("ov T+2");
    stepCycle("ov T+3"); stepCycle("ov T+4");

    // ERET.
    memValid = 1; eret = 1; cp0Epc = 32'h80001000; cp0Status = 32'h10000003;
    stepCycle("eret T");
    quiet();
    pin(mkWrite(5'd12, 32'h10000001, 1'b1, 1'b1)); stepCycle("eret T+1");
    pin(mkRedir(32'h80001000, 1'b0)); stepCycle("eret T+2");
    pin('0); stepCycle("eret T+3");

    // Pending interrupt without an instruction in MEM is held off.
    cp0Status = 32'h0000FF01; cp0Cause = 32'h00000400;
    pin('0); stepCycle("int novalid T");
    pin('0); stepCycle("int novalid T+1");

    // Interrupt beats RI; with EXL set RI is taken instead.
    memValid = 1; excVec = 7'b0000010;
    stepCycle("int T"); quiet(); stepCycle("int T+1");
    runSeq("int", 5'd0);
    memValid = 1; excVec = 7'b0000010; cp0Status = 32'h0000FF03; cp0Cause = 32'h00000400;
    stepCycle("ri T"); quiet(); stepCycle("ri T+1");
    runSeq("ri", 5'd10);

    // WB write forwarded in the accept cycle; later requests ignored while busy.
    memValid = 1; memPc = 32'h80000300; excVec = 7'b0010000;
    wbWe = 1; wbWaddr = 5'd11; wbWdata = 32'h12345678;
    pin(mkWrite(5'd11, 32'h12345678, 1'b0, 1'b0)); stepCycle("fwd T");
    leakCount = 0; redirCount = 0;
    for (int i = 1; i <= 4; i++) begin
      memValid = 1; excVec = 7'b0000001; wbWe = 1; wbWaddr = 5'd11; wbWdata = 32'hCAFE0000 + i;
      stepCycle("fwd busy");
    end
    quiet();
    repeat (4) stepCycle("fwd drain");
    checkCount("fwd no busy write", leakCount, 0);
    checkCount("fwd one redirect", redirCount, 1);

    // Reset during S_CAUSE, then a breakpoint runs a full sequence.
    memValid = 1; memPc = 32'h80000400; excVec = 7'b0010000;
    stepCycle("rst T"); quiet(); stepCycle("rst T+1");
    rst = 1'b0;
    pin('0); stepCycle("rst in S_CAUSE");
    rst = 1'b1;
    pin('0); stepCycle("rst released");
    memValid = 1; memPc = 32'h80000500; excVec = 7'b0100000;
    stepCycle("bp T"); quiet(); stepCycle("bp T+1");
    runSeq("bp", 5'd9);
    pin('0); stepCycle("bp T+5");

    for (int n = 0; n < 3000; n++) begin
      applyStimulus();
      stepCycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Exception/interrupt sequencer for the CP0 register file.
- Sits at the MEM/WB boundary and takes MEM-stage exception flags, ERET and pending interrupts.
- Drives the single CP0 write port to commit EPC, Cause and Status over successive cycles, then redirects the PC.
- Also forwards WB-stage MTC0 writes to CP0 when idle, and raises flush/stall to the pipeline.

Parameters:
- EXC_VECTOR, 32'hBFC00380, general exception entry address.
- ADDR_EPC, 5'd14, CP0 EPC register number.
- ADDR_CAUSE, 5'd13, CP0 Cause register number.
- ADDR_STATUS, 5'd12, CP0 Status register number.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- mem_valid_i  in  1  valid instruction in MEM.
- mem_pc_i  in  32  PC of MEM instruction.
- mem_in_dslot_i  in  1  MEM instruction is in a delay slot.
- exc_vec_i  in  7  flags: [0]AdEL [1]RI [2]Ov [3]Tr [4]Sys [5]Bp [6]AdES.
- eret_i  in  1  MEM instruction is ERET.
- cp0_status_i  in  32  current Status.
- cp0_cause_i  in  32  current Cause.
- cp0_epc_i  in  32  current EPC.
- wb_we_i  in  1  MTC0 write request from WB.
- wb_waddr_i  in  5  MTC0 target register.
- wb_wdata_i  in  32  MTC0 data.
- cp0_we_o  out  1  CP0 write enable.
- cp0_waddr_o  out  5  CP0 write address.
- cp0_wdata_o  out  32  CP0 write data.
- cause_we_o  out  1  exception Cause update; CP0 loads ExcCode[6:2] and BD[31] only.
- exccode_o  out  5  ExcCode value.
- bd_o  out  1  BD value.
- flush_o  out  1  flush IF..MEM/WB pipeline registers.
- stall_o  out  1  hold pipeline.
- redirect_o  out  1  load new_pc_o into PC.
- new_pc_o  out  32  redirect target.

Behaviour:
- Reset (rst=0, async): state=IDLE, all latches 0, every registered output 0.
- int_pend = status[0](IE) & ~status[1](EXL) & |(cause[15:8] & status[15:8]).
- Accept, IDLE only, when mem_valid_i and any of int_pend, |exc_vec_i, eret_i.
- Priority at accept: Int(0) > AdEL(4) > RI(10) > Ov(12) > Tr(13) > Sys(8) > Bp(9) > AdES(5) > ERET. Codes are ExcCode values.
- Latched at accept:
  - code.
  - is_eret: set only if ERET is the winner.
  - epc_val = mem_in_dslot_i ? mem_pc_i-4 : mem_pc_i (mod 2^32).
  - bd = mem_in_dslot_i.
  - status snapshot.
  - cp0_epc_i.
- Exception sequence, accept in cycle T:
  - T+1 S_EPC: flush_o=1, stall_o=1, write EPC=epc_val.
  - T+2 S_CAUSE: stall_o=1, cause_we_o=1, exccode_o=code, bd_o=bd.
  - T+3 S_STATUS: stall_o=1, write Status = snapshot | 32'h2.
  - T+4 S_REDIR: stall_o=1, redirect_o=1, new_pc_o=EXC_VECTOR.
  - T+5 IDLE.
- ERET sequence:
  - T+1 S_STATUS: flush_o=1, stall_o=1, write Status = snapshot & ~32'h2.
  - T+2 S_REDIR: redirect_o=1, new_pc_o=latched EPC.
  - T+3 IDLE.
- flush_o, redirect_o and cause_we_o are exactly 1-cycle pulses.
- cp0_we_o is high only in write states; waddr/wdata are 0 otherwise.
- IDLE passthrough: cp0_we_o/waddr/wdata = wb_* combinationally.
  - A WB write in the accept cycle T is forwarded; the sequence starts at T+1 and sees its effect.
- Busy states (not IDLE):
  - wb_we_i, exc_vec_i, eret_i and interrupts are ignored; no nesting.
  - The faulting instruction is flushed, so no WB write is lost.
- Interrupt accepted with no instruction in MEM (mem_valid_i=0): not taken; waits for the next valid instruction.
- A new accept is allowed in the same cycle state returns to IDLE, e.g. at T+5.
- Reset mid-sequence returns to IDLE immediately; no partial-write completion.

Decomposition:
- Shared package/defines:
  - ExcCode constants.
  - CP0 register numbers.
  - Status bit indices IE=0, EXL=1.
  - State encoding IDLE/S_EPC/S_CAUSE/S_STATUS/S_REDIR.
- One natural sub-module: exc_prio_enc, a combinational priority encoder from int_pend/exc_vec_i/eret_i to {take, code, is_eret}.

Test Plan:
- Sys at pc=32'h80000100, no dslot, status=32'h10000001 -> writes in order:
  - T+1 EPC=32'h80000100, flush.
  - T+2 cause_we, exccode=8, bd=0.
  - T+3 Status=32'h10000003.
  - T+4 redirect to 32'hBFC00380.
- Ov in delay slot at pc=32'h80000204 -> EPC=32'h80000200, bd=1, exccode=12.
- ERET with epc=32'h80001000, status=32'h10000003 -> T+1 Status=32'h10000001; T+2 redirect to 32'h80001000.
- status=32'h0000FF01, cause[10]=1, plus RI flagged, mem_valid=1 -> exccode=0 (Int wins).
  - Repeat with status EXL=1 -> RI taken, exccode=10.
- wb MTC0 to Compare during accept cycle -> forwarded that cycle; further wb_we and exc during T+1..T+4 produce no CP0 write; exactly one redirect.
- rst low during S_CAUSE -> all outputs 0 immediately, state IDLE; a new Bp after release runs a full sequence with exccode=9.
